// File: rtl/ulpi_phy_emu.sv
// ulpi_phy_emu: PHY-side ULPI endpoint for exercising a link controller in FPGA.
// Accepts link transmits (TXCMD + payload) onto a byte stream. Turns an RX byte
// stream and a latched RX CMD into PHY-originated bus traffic, with turnaround.
// Optional feature macro: ULPI_PHY_TIMEOUT_EN compiles in the link transmit
// timeout counter. Without it, tx_timeout is tied low.
module ulpi_phy_emu #(
  parameter int TX_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  input  logic       ulpi_stp,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  output logic [7:0] txd_data,
  output logic       txd_valid,
  output logic       txd_first,
  output logic       txd_end,
  output logic       txd_abort,
  input  logic       txd_hold,
  input  logic [7:0] rxd_data,
  input  logic       rxd_valid,
  input  logic       rxd_last,
  output logic       rxd_ready,
  input  logic [7:0] rxcmd_data,
  input  logic       rxcmd_strobe,
  output logic       rxcmd_busy,
  output logic       tx_timeout
);

  typedef enum logic [2:0] {
    IDLE, LINK_TX, TURN_OUT, RX_DATA, RX_CMD, TURN_IN
  } state_t;

  state_t     state, state_next;
  logic       tx_nxt;       // registered throttle, only driven onto the bus in LINK_TX
  logic [7:0] rxcmd_q;      // last accepted RX CMD, kept as the gap filler
  logic       rxcmd_clear;  // the pending RX CMD has been put on the bus

  if (TX_TIMEOUT < 1) begin : g_bad_timeout
    $error("ulpi_phy_emu: TX_TIMEOUT must be at least 1");
  end

  // State register; reset drops the bus back to the link immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;  // NOTE: non-blocking for every flop so all registers update from pre-edge values.
  end

  // Next-state and bus outputs; RX-side outputs follow the RX inputs combinationally.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next   = state;
    ulpi_dir     = 1'b0;
    ulpi_nxt     = 1'b0;
    ulpi_data_o  = 8'h00;
    ulpi_data_oe = 1'b0;
    rxd_ready    = 1'b0;
    rxcmd_clear  = 1'b0;
    unique case (state)
      IDLE: begin
        // The PHY wins a same-cycle collision with a link TXCMD.
        if (rxd_valid || rxcmd_busy)  state_next = TURN_OUT;
        else if (ulpi_data_i != 8'h00) state_next = LINK_TX;
      end
      LINK_TX: begin
        ulpi_nxt = tx_nxt;
        if (ulpi_stp) state_next = IDLE;
      end
      TURN_OUT: begin
        ulpi_dir   = 1'b1;
        ulpi_nxt   = rxd_valid;  // RxActive start when a packet is waiting
        state_next = rxd_valid ? RX_DATA : RX_CMD;
      end
      RX_DATA: begin
        ulpi_dir     = 1'b1;
        ulpi_data_oe = 1'b1;
        if (rxd_valid) begin
          ulpi_data_o = rxd_data;
          ulpi_nxt    = 1'b1;
          rxd_ready   = 1'b1;
          if (rxd_last) state_next = TURN_IN;
        end else begin
          // Gap: report line state with RxActive still set.
          ulpi_data_o = rxcmd_q | 8'h10;
          rxcmd_clear = 1'b1;
        end
      end
      RX_CMD: begin
        ulpi_dir     = 1'b1;
        ulpi_data_oe = 1'b1;
        ulpi_data_o  = rxcmd_q;
        rxcmd_clear  = 1'b1;
        state_next   = TURN_IN;
      end
      TURN_IN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Link transmit capture: TXCMD from IDLE, payload on nxt, end/abort on stp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_nxt    <= 1'b0;
      txd_data  <= 8'h00;
      txd_valid <= 1'b0;
      txd_first <= 1'b0;
      txd_end   <= 1'b0;
      txd_abort <= 1'b0;
    end else begin
      txd_valid <= 1'b0;
      txd_first <= 1'b0;
      txd_end   <= 1'b0;
      txd_abort <= 1'b0;
      tx_nxt    <= (state_next == LINK_TX) && !txd_hold;
      if (state == IDLE && state_next == LINK_TX) begin
        txd_data  <= ulpi_data_i;
        txd_valid <= 1'b1;
        txd_first <= 1'b1;
      end else if (state == LINK_TX) begin
        if (ulpi_stp) begin
          // A byte offered together with stp is not transferred.
          txd_end   <= 1'b1;
          txd_abort <= (ulpi_data_i == 8'hFF);
        end else if (tx_nxt) begin
          txd_data  <= ulpi_data_i;
          txd_valid <= 1'b1;
        end
      end
    end
  end

  // RX CMD latch: one pending request at a time; value survives being sent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxcmd_q    <= 8'h00;
      rxcmd_busy <= 1'b0;
    end else if (rxcmd_strobe && !rxcmd_busy) begin
      rxcmd_q    <= rxcmd_data;
      rxcmd_busy <= 1'b1;
    end else if (rxcmd_clear) begin
      rxcmd_busy <= 1'b0;
    end
  end

`ifdef ULPI_PHY_TIMEOUT_EN
  localparam int CW = $clog2(TX_TIMEOUT + 1);
  logic [CW-1:0] tx_count;

  // Saturating LINK_TX cycle counter; pulses once on reaching TX_TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_count   <= '0;
      tx_timeout <= 1'b0;
    end else begin
      tx_timeout <= 1'b0;
      if (state != LINK_TX) begin
        tx_count <= '0;
      end else if (tx_count != CW'(TX_TIMEOUT)) begin
        tx_count   <= tx_count + CW'(1);
        tx_timeout <= (tx_count == CW'(TX_TIMEOUT - 1));
      end
    end
  end
`else
  assign tx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Bench for ulpi_phy_emu: directed scenarios followed by randomized link
// transmits, RX packets and RX CMDs, each checked against a transaction-level
// expectation built by the bench (byte lists and per-cycle bus traces).
module tb_ulpi_phy_emu;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ulpi_dir, ulpi_nxt, ulpi_stp, ulpi_data_oe;
  logic [7:0] ulpi_data_i, ulpi_data_o;
  logic [7:0] txd_data;
  logic       txd_valid, txd_first, txd_end, txd_abort, txd_hold;
  logic [7:0] rxd_data;
  logic       rxd_valid, rxd_last, rxd_ready;
  logic [7:0] rxcmd_data;
  logic       rxcmd_strobe, rxcmd_busy, tx_timeout;

  int errors = 0;
  int checks = 0;

  logic [7:0] lbytes[$];   // link transfer: TXCMD followed by payload
  logic [7:0] rbytes[$];   // RX packet bytes
  logic [8:0] slot[$];     // RX bus slots: {valid, byte}
  logic [7:0] rxcmd_lat = 8'h00;

  ulpi_phy_emu #(.TX_TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_stp(ulpi_stp),
    .ulpi_data_i(ulpi_data_i), .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe),
    .txd_data(txd_data), .txd_valid(txd_valid), .txd_first(txd_first),
    .txd_end(txd_end), .txd_abort(txd_abort), .txd_hold(txd_hold),
    .rxd_data(rxd_data), .rxd_valid(rxd_valid), .rxd_last(rxd_last), .rxd_ready(rxd_ready),
    .rxcmd_data(rxcmd_data), .rxcmd_strobe(rxcmd_strobe), .rxcmd_busy(rxcmd_busy),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] out_vec();
    return {ulpi_dir, ulpi_nxt, ulpi_data_oe, ulpi_data_o, txd_data, txd_valid,
            txd_first, txd_end, txd_abort, rxd_ready, rxcmd_busy, tx_timeout};
  endfunction

  function automatic bit pick_hold(input int cyc, input int pct, input int ff, input int fc);
    if (cyc >= ff && cyc < ff + fc) return 1'b1;
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  // Starts in an IDLE cycle with an RX CMD pending; walks turnaround, CMD, turn-in.
  task automatic expect_rxcmd(input logic [7:0] v);
    @(negedge clk); #1;
    check("rxcmd_turn_dir", ulpi_dir, 1);
    check("rxcmd_turn_oe", ulpi_data_oe, 0);
    check("rxcmd_turn_nxt", ulpi_nxt, 0);
    @(negedge clk); #1;
    check("rxcmd_dir", ulpi_dir, 1);
    check("rxcmd_oe", ulpi_data_oe, 1);
    check("rxcmd_nxt", ulpi_nxt, 0);
    check("rxcmd_data", ulpi_data_o, v);
    @(negedge clk); #1;
    check("rxcmd_turnin_dir", ulpi_dir, 0);
    check("rxcmd_turnin_oe", ulpi_data_oe, 0);
    check("rxcmd_busy_clear", rxcmd_busy, 0);
    @(negedge clk); #1;
    check("rxcmd_idle_dir", ulpi_dir, 0);
  endtask

  task automatic do_rxcmd(input logic [7:0] v);
    @(negedge clk);
    rxcmd_data = v; rxcmd_strobe = 1'b1;
    #1 check("rxcmd_busy_pre", rxcmd_busy, 0);
    @(negedge clk);
    rxcmd_strobe = 1'b0; rxcmd_data = 8'($urandom);
    #1 check("rxcmd_busy_set", rxcmd_busy, 1);
    check("rxcmd_wait_dir", ulpi_dir, 0);
    rxcmd_lat = v;
    expect_rxcmd(v);
  endtask

  // Link transmit of lbytes; optional RX CMD strobe while the link owns the bus.
  task automatic do_link(input int hold_pct, input int force_from, input int force_cnt,
                         input logic [7:0] stp_byte, input bit strobe_en, input logic [7:0] strobe_val);
    int idx, cyc, pulses, exp_pulses;
    bit took, hold_prev, hold_now, fin;
    logic [8:0] got[$];
    idx = 0; cyc = 0; pulses = 0; fin = 0;
    @(negedge clk);
    ulpi_data_i = lbytes[0]; ulpi_stp = 1'b0;
    hold_now = pick_hold(0, hold_pct, force_from, force_cnt);
    txd_hold = hold_now;
    #1 check("link_idle_dir", ulpi_dir, 0);
    hold_prev = hold_now; took = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (took) idx++;
      rxcmd_strobe = strobe_en && (cyc == 2);
      rxcmd_data   = strobe_val;
      if (idx < lbytes.size()) begin
        ulpi_data_i = lbytes[idx]; ulpi_stp = 1'b0;
      end else begin
        ulpi_data_i = stp_byte; ulpi_stp = 1'b1; fin = 1'b1;
      end
      hold_now = pick_hold(cyc, hold_pct, force_from, force_cnt);
      txd_hold = hold_now;
      #1;
      check("link_nxt", ulpi_nxt, !hold_prev);
      check("link_dir", ulpi_dir, 0);
      if (txd_valid) got.push_back({txd_first, txd_data});
      if (tx_timeout) pulses++;
      took = ulpi_nxt && !ulpi_stp;
      hold_prev = hold_now;
      if (cyc > 2000 && !fin) begin
        check("link_bound", 32'(cyc), 2000);
        fin = 1'b1;
      end
    end
    @(negedge clk);
    rxcmd_strobe = 1'b0; ulpi_stp = 1'b0; ulpi_data_i = 8'h00; txd_hold = 1'b0;
    #1;
    check("link_end", txd_end, 1);
    check("link_abort", txd_abort, stp_byte == 8'hFF);
    check("link_nxt_drop", ulpi_nxt, 0);
    if (txd_valid) got.push_back({txd_first, txd_data});
    if (tx_timeout) pulses++;
    check("link_count", got.size(), lbytes.size());
    for (int i = 0; i < got.size() && i < lbytes.size(); i++)
      check("link_byte", got[i], {1'(i == 0), lbytes[i]});
`ifdef ULPI_PHY_TIMEOUT_EN
    exp_pulses = (cyc >= 255) ? 1 : 0;
`else
    exp_pulses = 0;
`endif
    check("tx_timeout_pulses", pulses, exp_pulses);
    if (strobe_en) begin
      check("defer_busy", rxcmd_busy, 1);
      rxcmd_lat = strobe_val;
      expect_rxcmd(strobe_val);
    end
  endtask

  // RX packet of rbytes; gap before index gap_at and/or random gaps; optional
  // same-cycle link TXCMD collision and reset at slot rst_at.
  task automatic do_rx(input int gap_pct, input int gap_at, input bit collide, input int rst_at);
    bit v;
    slot.delete();
    for (int i = 0; i < rbytes.size(); i++) begin
      if (i > 0 && (i == gap_at || int'($urandom_range(0, 99)) < gap_pct))
        slot.push_back({1'b0, 8'h00});
      slot.push_back({1'b1, rbytes[i]});
    end
    @(negedge clk);
    rxd_valid = 1'b1; rxd_data = rbytes[0]; rxd_last = (rbytes.size() == 1);
    if (collide) ulpi_data_i = 8'($urandom_range(1, 255));
    #1 check("rx_req_dir", ulpi_dir, 0);
    @(negedge clk);
    ulpi_data_i = 8'h00;
    #1;
    check("rx_turn_dir", ulpi_dir, 1);
    check("rx_turn_oe", ulpi_data_oe, 0);
    check("rx_turn_nxt", ulpi_nxt, 1);
    check("rx_turn_ready", rxd_ready, 0);
    check("rx_no_txd", txd_valid, 0);
    for (int s = 0; s < slot.size(); s++) begin
      @(negedge clk);
      v = slot[s][8];
      rxd_valid = v;
      rxd_data  = v ? slot[s][7:0] : 8'($urandom);
      rxd_last  = v && (s == slot.size() - 1);
      if (s == rst_at) begin
        reset_n = 1'b0;
        #1 check("reset_mid_rx", {6'd0, out_vec()}, 0);
        rxd_valid = 1'b0; rxd_last = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; rxcmd_lat = 8'h00;
        #1 check("reset_release_dir", ulpi_dir, 0);
        return;
      end
      #1;
      check("rx_dir", ulpi_dir, 1);
      check("rx_oe", ulpi_data_oe, 1);
      check("rx_nxt", ulpi_nxt, v);
      check("rx_ready", rxd_ready, v);
      check("rx_data", ulpi_data_o, v ? slot[s][7:0] : (rxcmd_lat | 8'h10));
      check("rx_no_txd", txd_valid, 0);
    end
    @(negedge clk);
    rxd_valid = 1'b0; rxd_last = 1'b0;
    #1;
    check("rx_turnin_dir", ulpi_dir, 0);
    check("rx_turnin_oe", ulpi_data_oe, 0);
    check("rx_turnin_nxt", ulpi_nxt, 0);
    check("rx_busy", rxcmd_busy, 0);
    @(negedge clk); #1;
    check("rx_idle_dir", ulpi_dir, 0);
    check("rx_idle_no_txd", txd_valid, 0);
  endtask

  initial begin
    int op, n;
    ulpi_stp = 1'b0; ulpi_data_i = 8'h00; txd_hold = 1'b0;
    rxd_data = 8'h00; rxd_valid = 1'b0; rxd_last = 1'b0;
    rxcmd_data = 8'h00; rxcmd_strobe = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", {6'd0, out_vec()}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Plain link transmit.
    lbytes = '{8'h42, 8'h11, 8'h22, 8'h33};
    do_link(0, -1, 0, 8'h00, 1'b0, 8'h00);

    // Two-cycle throttle mid-packet, then abort.
    lbytes = '{8'h45, 8'h5A, 8'hC3, 8'h0F, 8'h99};
    do_link(0, 2, 2, 8'hFF, 1'b0, 8'h00);

    // Three-byte RX packet without gaps.
    rbytes = '{8'hA1, 8'hA2, 8'hA3};
    do_rx(0, -1, 1'b0, -1);

    // Latch 8'h0C via a standalone RX CMD, then a packet with a one-cycle gap.
    do_rxcmd(8'h0C);
    rbytes = '{8'hB1, 8'hB2, 8'hB3};
    do_rx(0, 1, 1'b0, -1);

    // RX CMD strobed during a link transmit is deferred until stp.
    lbytes = '{8'h48, 8'h01, 8'h02, 8'h03};
    do_link(0, -1, 0, 8'h00, 1'b1, 8'h03);

    // RX request and link TXCMD in the same IDLE cycle.
    rbytes = '{8'hD4, 8'hD5};
    do_rx(0, -1, 1'b1, -1);

    // Long transmit held open past TX_TIMEOUT.
    lbytes = '{8'h41, 8'h77};
    do_link(0, 1, 300, 8'h00, 1'b0, 8'h00);

    // Randomized mix.
    for (int k = 0; k < 30; k++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        lbytes.delete();
        lbytes.push_back(8'($urandom_range(1, 255)));
        n = int'($urandom_range(0, 6));
        for (int i = 0; i < n; i++) lbytes.push_back(8'($urandom));
        do_link(int'($urandom_range(0, 50)), -1, 0, ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                1'b0, 8'h00);
      end else if (op == 1) begin
        rbytes.delete();
        n = int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) rbytes.push_back(8'($urandom));
        do_rx(int'($urandom_range(0, 40)), -1, 1'($urandom_range(0, 1)), -1);
      end else begin
        do_rxcmd(8'($urandom));
      end
    end

    // Asynchronous reset while in RX_DATA.
    rbytes = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    do_rx(0, -1, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
